// File: rtl/triangle_scan_rasterizer.sv
// triangle_scan_rasterizer: accepts one triangle per handshake, computes a screen-clamped
// bounding box and incremental edge functions, then scans the box row-major at one pixel
// per cycle. Covered pixels leave on a valid/ready fragment stream with full backpressure.
// Optional feature macro: RASTER_BARY_EN adds frag_w1/frag_w2/frag_w3/frag_area outputs.
module triangle_scan_rasterizer #(
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned SCREEN_H  = 480,
    parameter bit          CULL_BACK = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        tri_valid,
    output logic                        tri_ready,
    input  logic [COORD_W-1:0]          v1x,
    input  logic [COORD_W-1:0]          v1y,
    input  logic [COORD_W-1:0]          v2x,
    input  logic [COORD_W-1:0]          v2y,
    input  logic [COORD_W-1:0]          v3x,
    input  logic [COORD_W-1:0]          v3y,
    output logic                        frag_valid,
    input  logic                        frag_ready,
    output logic [COORD_W-1:0]          frag_x,
    output logic [COORD_W-1:0]          frag_y,
    output logic                        tri_done,
`ifdef RASTER_BARY_EN
    output logic signed [2*COORD_W+2:0] frag_w1,
    output logic signed [2*COORD_W+2:0] frag_w2,
    output logic signed [2*COORD_W+2:0] frag_w3,
    output logic signed [2*COORD_W+2:0] frag_area,
`endif
    output logic                        busy
);

    localparam int unsigned EW = 2 * COORD_W + 3;
    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);
    localparam int NXT [3] = '{1, 2, 0};

    typedef logic signed [EW-1:0] ew_t;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SCAN, S_DRAIN, S_DONE} state_e;

    function automatic ew_t sext(input logic [COORD_W-1:0] v);
        return ew_t'({{(EW-COORD_W){1'b0}}, v});
    endfunction

    // E(a,b,p) = (bx-ax)(py-ay) - (by-ay)(px-ax); the true value always fits in EW bits
    function automatic ew_t edge_fn(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                    input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by,
                                    input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py);
        ew_t dx, dy, qx, qy;
        dx = sext(bx) - sext(ax);
        dy = sext(by) - sext(ay);
        qx = sext(px) - sext(ax);
        qy = sext(py) - sext(ay);
        return (dx * qy) - (dy * qx);
    endfunction

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                                 input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    state_e             state_q;
    logic [COORD_W-1:0] vx_q [3];
    logic [COORD_W-1:0] vy_q [3];
    logic [COORD_W-1:0] xmin_q, xmax_q, ymax_q;
    logic [COORD_W-1:0] x_q, y_q;
    ew_t                a_q [3];
    ew_t                b_q [3];
    ew_t                w_q [3];
    ew_t                wrow_q [3];
    logic               drain_q;
    logic               tri_ready_q, busy_q, tri_done_q, frag_valid_q;
    logic [COORD_W-1:0] frag_x_q, frag_y_q;
`ifdef RASTER_BARY_EN
    ew_t                area_q;
    ew_t                fw_q [3];
    ew_t                farea_q;
`endif

    logic [COORD_W-1:0] xmin_c, xmax_c, ymin_c, ymax_c;
    ew_t                area_c;
    logic               neg_c, cull_c;
    ew_t                a_c [3];
    ew_t                b_c [3];
    ew_t                w0_c [3];
    logic               cov_c, adv_c, last_col_c, last_row_c;

    // Triangle setup from latched vertices: clamped box, area, per-edge step and start values
    always_comb begin
        xmin_c = clamp(min3(vx_q[0], vx_q[1], vx_q[2]), X_LIM);
        xmax_c = clamp(max3(vx_q[0], vx_q[1], vx_q[2]), X_LIM);
        ymin_c = clamp(min3(vy_q[0], vy_q[1], vy_q[2]), Y_LIM);
        ymax_c = clamp(max3(vy_q[0], vy_q[1], vy_q[2]), Y_LIM);
        area_c = edge_fn(vx_q[0], vy_q[0], vx_q[1], vy_q[1], vx_q[2], vy_q[2]);
        neg_c  = area_c[EW-1];
        cull_c = (area_c == '0) || (neg_c && CULL_BACK);
        for (int i = 0; i < 3; i++) begin
            a_c[i]  = sext(vy_q[i]) - sext(vy_q[NXT[i]]);
            b_c[i]  = sext(vx_q[NXT[i]]) - sext(vx_q[i]);
            w0_c[i] = edge_fn(vx_q[i], vy_q[i], vx_q[NXT[i]], vy_q[NXT[i]], xmin_c, ymin_c);
            // Clockwise triangles kept by disabling culling are flipped so >=0 still means inside
            if (neg_c) begin
                a_c[i]  = -a_c[i];
                b_c[i]  = -b_c[i];
                w0_c[i] = -w0_c[i];
            end
        end
    end

    // Per-pixel coverage and scan-advance qualifiers
    always_comb begin
        cov_c      = !w_q[0][EW-1] && !w_q[1][EW-1] && !w_q[2][EW-1];
        adv_c      = !frag_valid_q || frag_ready;
        last_col_c = (x_q == xmax_q);
        last_row_c = (y_q == ymax_q);
    end

    // Control FSM, scan datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            xmin_q       <= '0;
            xmax_q       <= '0;
            ymax_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            drain_q      <= 1'b0;
            tri_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            tri_done_q   <= 1'b0;
            frag_valid_q <= 1'b0;
            frag_x_q     <= '0;
            frag_y_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                vx_q[i]   <= '0;
                vy_q[i]   <= '0;
                a_q[i]    <= '0;
                b_q[i]    <= '0;
                w_q[i]    <= '0;
                wrow_q[i] <= '0;
            end
`ifdef RASTER_BARY_EN
            area_q  <= '0;
            farea_q <= '0;
            for (int i = 0; i < 3; i++) fw_q[i] <= '0;
`endif
        end else begin
            tri_done_q <= 1'b0;
            if (frag_valid_q && frag_ready) frag_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tri_valid && tri_ready_q) begin
                        vx_q[0]     <= v1x;
                        vy_q[0]     <= v1y;
                        vx_q[1]     <= v2x;
                        vy_q[1]     <= v2y;
                        vx_q[2]     <= v3x;
                        vy_q[2]     <= v3y;
                        tri_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    xmin_q <= xmin_c;
                    xmax_q <= xmax_c;
                    ymax_q <= ymax_c;
                    x_q    <= xmin_c;
                    y_q    <= ymin_c;
                    for (int i = 0; i < 3; i++) begin
                        a_q[i]    <= a_c[i];
                        b_q[i]    <= b_c[i];
                        w_q[i]    <= w0_c[i];
                        wrow_q[i] <= w0_c[i];
                    end
`ifdef RASTER_BARY_EN
                    area_q <= neg_c ? -area_c : area_c;
`endif
                    if (cull_c) begin
                        tri_done_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        state_q    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (adv_c) begin
                        if (cov_c) begin
                            frag_valid_q <= 1'b1;
                            frag_x_q     <= x_q;
                            frag_y_q     <= y_q;
`ifdef RASTER_BARY_EN
                            for (int i = 0; i < 3; i++) fw_q[i] <= w_q[i];
                            farea_q <= area_q;
`endif
                        end
                        if (last_col_c) begin
                            if (last_row_c) begin
                                drain_q <= 1'b0;
                                state_q <= S_DRAIN;
                            end else begin
                                x_q <= xmin_q;
                                y_q <= y_q + COORD_W'(1);
                                for (int i = 0; i < 3; i++) begin
                                    wrow_q[i] <= wrow_q[i] + b_q[i];
                                    w_q[i]    <= wrow_q[i] + b_q[i];
                                end
                            end
                        end else begin
                            x_q <= x_q + COORD_W'(1);
                            for (int i = 0; i < 3; i++) w_q[i] <= w_q[i] + a_q[i];
                        end
                    end
                end
                S_DRAIN: begin
                    // One settle cycle keeps done latency fixed whether or not the last pixel hit
                    drain_q <= 1'b1;
                    if (drain_q && !frag_valid_q) begin
                        tri_done_q <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    drain_q     <= 1'b0;
                    tri_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    tri_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign tri_ready  = tri_ready_q;
    assign busy       = busy_q;
    assign tri_done   = tri_done_q;
    assign frag_valid = frag_valid_q;
    assign frag_x     = frag_x_q;
    assign frag_y     = frag_y_q;
`ifdef RASTER_BARY_EN
    assign frag_w1    = fw_q[0];
    assign frag_w2    = fw_q[1];
    assign frag_w3    = fw_q[2];
    assign frag_area  = farea_q;
`endif

endmodule

// File: tb/tb_triangle_scan_rasterizer.sv
// Directed bench for triangle_scan_rasterizer: a direct-formula model fills a fragment
// scoreboard per triangle; DUT fragments are popped and compared at each handshake.
module tb_triangle_scan_rasterizer;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned EW      = 2 * COORD_W + 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tri_valid_a = 1'b0;
    logic tri_valid_b = 1'b0;
    logic frag_ready = 1'b1;
    logic sel_b = 1'b0;
    logic [COORD_W-1:0] v1x = '0, v1y = '0, v2x = '0, v2y = '0, v3x = '0, v3y = '0;

    logic a_tri_ready, a_frag_valid, a_tri_done, a_busy;
    logic b_tri_ready, b_frag_valid, b_tri_done, b_busy;
    logic [COORD_W-1:0] a_frag_x, a_frag_y, b_frag_x, b_frag_y;
    logic m_tri_ready, m_frag_valid, m_tri_done, m_busy;
    logic [COORD_W-1:0] m_frag_x, m_frag_y;
`ifdef RASTER_BARY_EN
    logic signed [EW-1:0] a_w1, a_w2, a_w3, a_area, b_w1, b_w2, b_w3, b_area;
    logic signed [EW-1:0] m_w1, m_w2, m_w3, m_area;
`endif

    int checks = 0;
    int errors = 0;
    logic [2*COORD_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    triangle_scan_rasterizer #(.COORD_W(COORD_W), .SCREEN_W(640), .SCREEN_H(480), .CULL_BACK(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .tri_valid(tri_valid_a), .tri_ready(a_tri_ready),
        .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
        .frag_valid(a_frag_valid), .frag_ready(frag_ready), .frag_x(a_frag_x), .frag_y(a_frag_y),
        .tri_done(a_tri_done),
`ifdef RASTER_BARY_EN
        .frag_w1(a_w1), .frag_w2(a_w2), .frag_w3(a_w3), .frag_area(a_area),
`endif
        .busy(a_busy)
    );

    triangle_scan_rasterizer #(.COORD_W(COORD_W), .SCREEN_W(640), .SCREEN_H(480), .CULL_BACK(1'b0)) u_dut_nc (
        .clk(clk), .reset_n(reset_n), .tri_valid(tri_valid_b), .tri_ready(b_tri_ready),
        .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
        .frag_valid(b_frag_valid), .frag_ready(frag_ready), .frag_x(b_frag_x), .frag_y(b_frag_y),
        .tri_done(b_tri_done),
`ifdef RASTER_BARY_EN
        .frag_w1(b_w1), .frag_w2(b_w2), .frag_w3(b_w3), .frag_area(b_area),
`endif
        .busy(b_busy)
    );

    assign m_tri_ready  = sel_b ? b_tri_ready  : a_tri_ready;
    assign m_frag_valid = sel_b ? b_frag_valid : a_frag_valid;
    assign m_tri_done   = sel_b ? b_tri_done   : a_tri_done;
    assign m_busy       = sel_b ? b_busy       : a_busy;
    assign m_frag_x     = sel_b ? b_frag_x     : a_frag_x;
    assign m_frag_y     = sel_b ? b_frag_y     : a_frag_y;
`ifdef RASTER_BARY_EN
    assign m_w1   = sel_b ? b_w1   : a_w1;
    assign m_w2   = sel_b ? b_w2   : a_w2;
    assign m_w3   = sel_b ? b_w3   : a_w3;
    assign m_area = sel_b ? b_area : a_area;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint edge_m(input longint ax, input longint ay, input longint bx,
                                      input longint by, input longint px, input longint py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Direct-formula model: fills the scoreboard with covered pixels of the clamped box
    task automatic build_expected(input int x1, input int y1, input int x2, input int y2,
                                  input int x3, input int y3, input bit cull,
                                  output int n_box, output bit drop);
        longint ar, w1, w2, w3;
        int lo_x, hi_x, lo_y, hi_y;
        ar   = edge_m(x1, y1, x2, y2, x3, y3);
        lo_x = imin(imin(imin(x1, x2), x3), 639);
        hi_x = imin(imax(imax(x1, x2), x3), 639);
        lo_y = imin(imin(imin(y1, y2), y3), 479);
        hi_y = imin(imax(imax(y1, y2), y3), 479);
        n_box = (hi_x - lo_x + 1) * (hi_y - lo_y + 1);
        drop  = (ar == 0) || (ar < 0 && cull);
        exp_q.delete();
        if (!drop) begin
            for (int y = lo_y; y <= hi_y; y++) begin
                for (int x = lo_x; x <= hi_x; x++) begin
                    w1 = edge_m(x1, y1, x2, y2, x, y);
                    w2 = edge_m(x2, y2, x3, y3, x, y);
                    w3 = edge_m(x3, y3, x1, y1, x, y);
                    if (ar < 0) begin
                        w1 = -w1;
                        w2 = -w2;
                        w3 = -w3;
                    end
                    if (w1 >= 0 && w2 >= 0 && w3 >= 0) exp_q.push_back({COORD_W'(x), COORD_W'(y)});
                end
            end
        end
    endtask

    // Drives one triangle and checks fragments, stall stability and done timing until done
    task automatic run_tri(input string tag, input int x1, input int y1, input int x2, input int y2,
                           input int x3, input int y3, input bit use_b, input int stall_n,
                           input int reset_at);
        int n_box, exp_done, n_acc, stall_left;
        bit drop, prev_stall, done_seen;
        logic [COORD_W-1:0] px, py;
        logic [2*COORD_W-1:0] e;
        longint ar, sg;
        build_expected(x1, y1, x2, y2, x3, y3, !use_b, n_box, drop);
        exp_done   = drop ? 2 : n_box + 4 + stall_n;
        ar         = edge_m(x1, y1, x2, y2, x3, y3);
        sg         = (ar < 0) ? -1 : 1;
        n_acc      = 0;
        stall_left = stall_n;
        prev_stall = 1'b0;
        done_seen  = 1'b0;
        px         = '0;
        py         = '0;
        sel_b      = use_b;
        frag_ready = 1'b1;
        @(negedge clk);
        check({tag, "_ready_idle"}, 64'(m_tri_ready), 1);
        v1x = COORD_W'(x1); v1y = COORD_W'(y1);
        v2x = COORD_W'(x2); v2y = COORD_W'(y2);
        v3x = COORD_W'(x3); v3y = COORD_W'(y3);
        tri_valid_a = !use_b;
        tri_valid_b = use_b;
        for (int rel = 1; rel <= exp_done + 40 && !done_seen; rel++) begin
            @(negedge clk);
            if (rel == 1) begin
                tri_valid_a = 1'b0;
                tri_valid_b = 1'b0;
                check({tag, "_ready_low"}, 64'(m_tri_ready), 0);
                check({tag, "_busy"}, 64'(m_busy), 1);
            end
            if (rel == reset_at) begin
                reset_n = 1'b0;
                #1;
                check({tag, "_rst_ready"}, 64'(m_tri_ready), 1);
                check({tag, "_rst_valid"}, 64'(m_frag_valid), 0);
                check({tag, "_rst_done"}, 64'(m_tri_done), 0);
                check({tag, "_rst_busy"}, 64'(m_busy), 0);
                check({tag, "_rst_x"}, 64'(m_frag_x), 0);
                check({tag, "_rst_y"}, 64'(m_frag_y), 0);
                exp_q.delete();
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (stall_left > 0 && n_acc == 1 && m_frag_valid) begin
                frag_ready = 1'b0;
                stall_left--;
            end else begin
                frag_ready = 1'b1;
            end
            if (prev_stall) begin
                check({tag, "_hold_valid"}, 64'(m_frag_valid), 1);
                check({tag, "_hold_x"}, 64'(m_frag_x), 64'(px));
                check({tag, "_hold_y"}, 64'(m_frag_y), 64'(py));
            end
            prev_stall = m_frag_valid && !frag_ready;
            px = m_frag_x;
            py = m_frag_y;
            if (m_frag_valid && frag_ready) begin
                check({tag, "_frag_expected"}, 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_frag_x"}, 64'(m_frag_x), 64'(e[2*COORD_W-1:COORD_W]));
                    check({tag, "_frag_y"}, 64'(m_frag_y), 64'(e[COORD_W-1:0]));
`ifdef RASTER_BARY_EN
                    check({tag, "_w1"}, 64'(m_w1), 64'(sg * edge_m(x1, y1, x2, y2, m_frag_x, m_frag_y)));
                    check({tag, "_w2"}, 64'(m_w2), 64'(sg * edge_m(x2, y2, x3, y3, m_frag_x, m_frag_y)));
                    check({tag, "_w3"}, 64'(m_w3), 64'(sg * edge_m(x3, y3, x1, y1, m_frag_x, m_frag_y)));
                    check({tag, "_area"}, 64'(m_area), 64'(sg * ar));
`endif
                end
                n_acc++;
            end
            if (m_tri_done) begin
                done_seen = 1'b1;
                check({tag, "_done_cycle"}, 64'(rel), 64'(exp_done));
                check({tag, "_missing_frags"}, 64'(exp_q.size()), 0);
            end
        end
        frag_ready = 1'b1;
        check({tag, "_done_seen"}, 64'(done_seen), 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(m_tri_done), 0);
        check({tag, "_ready_back"}, 64'(m_tri_ready), 1);
        check({tag, "_idle"}, 64'(m_busy), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(a_tri_ready), 1);
        check("reset_valid", 64'(a_frag_valid), 0);
        check("reset_done", 64'(a_tri_done), 0);
        check("reset_busy", 64'(a_busy), 0);
        check("reset_x", 64'(a_frag_x), 0);
        check("reset_y", 64'(a_frag_y), 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_tri("ccw",       0, 0, 4, 0, 0, 4,    1'b0, 0, -1);
        run_tri("collinear", 0, 0, 2, 2, 4, 4,    1'b0, 0, -1);
        run_tri("cw_cull",   0, 0, 0, 4, 4, 0,    1'b0, 0, -1);
        run_tri("cw_keep",   0, 0, 0, 4, 4, 0,    1'b1, 0, -1);
        run_tri("generic",   3, 2, 12, 5, 6, 11,  1'b0, 0, -1);
        run_tri("clamp",     600, 10, 1023, 10, 600, 20, 1'b0, 0, -1);
        run_tri("stall",     0, 0, 4, 0, 0, 4,    1'b0, 3, -1);
        run_tri("mid_reset", 0, 0, 4, 0, 0, 4,    1'b0, 0, 10);
        run_tri("after_rst", 0, 0, 4, 0, 0, 4,    1'b0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
